// File: rtl/hpdmc_dqbus_if.sv
// Host-side interface of the HPDMC DQ/DM datapath: write beats, read issue/return and busy.
// The master is the controller; the slave is hpdmc_dqbus.
interface hpdmc_dqbus_if #(
    parameter int DW = 16
);
    logic            wr_valid;
    logic            wr_ready;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_be;
    logic            rd_issue;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            busy;

    modport master (
        output wr_valid, wr_data, wr_be, rd_issue,
        input  wr_ready, rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_valid, wr_data, wr_be, rd_issue,
        output wr_ready, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/hpdmc_dqbus.sv
// Registered SDRAM DQ/DM front-end: drives write beats onto the pads, captures read beats
// after CL cycles and holds off writes for TURN idle cycles once the read pipeline drains.
module hpdmc_dqbus #(
    parameter int DW   = 16,
    parameter int CL   = 2,
    parameter int TURN = 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    hpdmc_dqbus_if.slave    bus,
    input  logic [DW-1:0]   dq_i,
    output logic [DW-1:0]   dq_o,
    output logic [DW-1:0]   dq_t,
    output logic [DW/8-1:0] dm_o
);
    localparam int          BW     = DW / 8;
    localparam logic [2:0]  TURN_L = 3'(TURN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_READ,
        S_TURN
    } state_t;

    state_t          state_q, state_d;
    logic [CL-1:0]   pipe_q, pipe_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [DW-1:0]   dq_o_q, dq_o_d;
    logic [DW-1:0]   dq_t_q, dq_t_d;
    logic [BW-1:0]   dm_o_q, dm_o_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            wr_ready;
    logic            accept;

    // A read issued this cycle wins over a write, so the bus is never driven into a pending read.
    assign wr_ready = ((state_q == S_IDLE) || (state_q == S_DRIVE)) &&
                      (pipe_q == '0) && (cnt_q == 3'd0) && !bus.rd_issue;
    assign accept   = bus.wr_valid && wr_ready;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = bus.rd_issue;
        for (int i = 1; i < CL; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        dq_o_d     = accept ? bus.wr_data : dq_o_q;
        dq_t_d     = accept ? '0 : '1;
        dm_o_d     = accept ? ~bus.wr_be : '1;
        rd_valid_d = pipe_q[CL-1];
        rd_data_d  = pipe_q[CL-1] ? dq_i : rd_data_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (pipe_d != '0) begin
            state_d = S_READ;
            cnt_d   = 3'd0;
        end else if (pipe_q != '0) begin
            // Pipeline just drained: start the read-to-write turnaround.
            cnt_d   = TURN_L;
            state_d = (TURN_L == 3'd0) ? S_IDLE : S_TURN;
        end else if (cnt_q != 3'd0) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? S_IDLE : S_TURN;
        end else begin
            state_d = accept ? S_DRIVE : S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            pipe_q     <= '0;
            cnt_q      <= 3'd0;
            dq_o_q     <= '0;
            dq_t_q     <= '1;
            dm_o_q     <= '1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_q     <= pipe_d;
            cnt_q      <= cnt_d;
            dq_o_q     <= dq_o_d;
            dq_t_q     <= dq_t_d;
            dm_o_q     <= dm_o_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign dq_o         = dq_o_q;
    assign dq_t         = dq_t_q;
    assign dm_o         = dm_o_q;
    assign bus.wr_ready = wr_ready;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (pipe_q != '0) || (cnt_q != 3'd0) || !(&dq_t_q);
endmodule

// File: tb/tb_hpdmc_dqbus.sv
// Directed, table-driven bench for hpdmc_dqbus with DW=16, CL=2, TURN=2.
module tb_hpdmc_dqbus;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] dq_i;
    logic [DW-1:0] dq_o;
    logic [DW-1:0] dq_t;
    logic [1:0]    dm_o;

    int checks = 0;
    int errors = 0;

    hpdmc_dqbus_if #(.DW(DW)) bus ();

    hpdmc_dqbus #(.DW(DW), .CL(2), .TURN(2)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus),
        .dq_i      (dq_i),
        .dq_o      (dq_o),
        .dq_t      (dq_t),
        .dm_o      (dm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        ri;
        logic [15:0] dqi;
        logic        e_wr;
        logic        e_rv;
        logic [15:0] e_rd;
        logic        e_busy;
        logic [15:0] e_dqo;
        logic [15:0] e_dqt;
        logic [1:0]  e_dm;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic wv, input logic [15:0] wd, input logic [1:0] be,
                          input logic ri, input logic [15:0] dqi,
                          input logic e_wr, input logic e_rv, input logic [15:0] e_rd,
                          input logic e_busy, input logic [15:0] e_dqo,
                          input logic [15:0] e_dqt, input logic [1:0] e_dm);
        vec_t v;
        v.wv = wv; v.wd = wd; v.be = be; v.ri = ri; v.dqi = dqi;
        v.e_wr = e_wr; v.e_rv = e_rv; v.e_rd = e_rd; v.e_busy = e_busy;
        v.e_dqo = e_dqo; v.e_dqt = e_dqt; v.e_dm = e_dm;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic wv, input logic [15:0] wd, input logic [1:0] be,
                                 input logic ri, input logic [15:0] dqi);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.wr_be    = be;
        bus.rd_issue = ri;
        dq_i         = dqi;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    initial begin
        // Cycle-by-cycle table: inputs held during the cycle, outputs observed in that cycle.
        //     wv  wd        be     ri  dqi        wr  rv  rd        busy dq_o      dq_t      dm
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 2'b11); // 0
        addVec(1, 16'hA55A, 2'b01, 0, 16'h0000,  1, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 2'b11); // 1
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h0000, 1, 16'hA55A, 16'h0000, 2'b10); // 2
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h0000, 0, 16'hA55A, 16'hFFFF, 2'b11); // 3
        addVec(1, 16'h1111, 2'b11, 0, 16'h0000,  1, 0, 16'h0000, 0, 16'hA55A, 16'hFFFF, 2'b11); // 4
        addVec(1, 16'h2222, 2'b10, 0, 16'h0000,  1, 0, 16'h0000, 1, 16'h1111, 16'h0000, 2'b00); // 5
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h0000, 1, 16'h2222, 16'h0000, 2'b01); // 6
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h0000, 0, 16'h2222, 16'hFFFF, 2'b11); // 7
        addVec(0, 16'h0000, 2'b00, 1, 16'h0000,  0, 0, 16'h0000, 0, 16'h2222, 16'hFFFF, 2'b11); // 8
        addVec(0, 16'h0000, 2'b00, 0, 16'hFFFF,  0, 0, 16'h0000, 1, 16'h2222, 16'hFFFF, 2'b11); // 9
        addVec(0, 16'h0000, 2'b00, 0, 16'h1234,  0, 0, 16'h0000, 1, 16'h2222, 16'hFFFF, 2'b11); // 10
        addVec(0, 16'h0000, 2'b00, 0, 16'hFFFF,  0, 1, 16'h1234, 1, 16'h2222, 16'hFFFF, 2'b11); // 11
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 0, 16'h1234, 1, 16'h2222, 16'hFFFF, 2'b11); // 12
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h1234, 0, 16'h2222, 16'hFFFF, 2'b11); // 13
        addVec(1, 16'hBEEF, 2'b11, 1, 16'h0000,  0, 0, 16'h1234, 0, 16'h2222, 16'hFFFF, 2'b11); // 14
        addVec(1, 16'hBEEF, 2'b11, 0, 16'h0000,  0, 0, 16'h1234, 1, 16'h2222, 16'hFFFF, 2'b11); // 15
        addVec(1, 16'hBEEF, 2'b11, 0, 16'h5A5A,  0, 0, 16'h1234, 1, 16'h2222, 16'hFFFF, 2'b11); // 16
        addVec(1, 16'hBEEF, 2'b11, 0, 16'h0000,  0, 1, 16'h5A5A, 1, 16'h2222, 16'hFFFF, 2'b11); // 17
        addVec(1, 16'hBEEF, 2'b11, 0, 16'h0000,  0, 0, 16'h5A5A, 1, 16'h2222, 16'hFFFF, 2'b11); // 18
        addVec(1, 16'hBEEF, 2'b11, 0, 16'h0000,  1, 0, 16'h5A5A, 0, 16'h2222, 16'hFFFF, 2'b11); // 19
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h5A5A, 1, 16'hBEEF, 16'h0000, 2'b00); // 20
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h5A5A, 0, 16'hBEEF, 16'hFFFF, 2'b11); // 21
        addVec(0, 16'h0000, 2'b00, 1, 16'h0000,  0, 0, 16'h5A5A, 0, 16'hBEEF, 16'hFFFF, 2'b11); // 22
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 0, 16'h5A5A, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 23
        addVec(0, 16'h0000, 2'b00, 0, 16'h0C0C,  0, 0, 16'h5A5A, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 24
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 1, 16'h0C0C, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 25
        addVec(0, 16'h0000, 2'b00, 1, 16'h0000,  0, 0, 16'h0C0C, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 26
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 0, 16'h0C0C, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 27
        addVec(0, 16'h0000, 2'b00, 0, 16'h7777,  0, 0, 16'h0C0C, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 28
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 1, 16'h7777, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 29
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 0, 16'h7777, 1, 16'hBEEF, 16'hFFFF, 2'b11); // 30
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'h7777, 0, 16'hBEEF, 16'hFFFF, 2'b11); // 31
        addVec(1, 16'h3C3C, 2'b11, 0, 16'h0000,  1, 0, 16'h7777, 0, 16'hBEEF, 16'hFFFF, 2'b11); // 32
        addVec(0, 16'h0000, 2'b00, 1, 16'h0000,  0, 0, 16'h7777, 1, 16'h3C3C, 16'h0000, 2'b00); // 33
        addVec(0, 16'h0000, 2'b00, 1, 16'h0000,  0, 0, 16'h7777, 1, 16'h3C3C, 16'hFFFF, 2'b11); // 34
        addVec(0, 16'h0000, 2'b00, 0, 16'hAAAA,  0, 0, 16'h7777, 1, 16'h3C3C, 16'hFFFF, 2'b11); // 35
        addVec(0, 16'h0000, 2'b00, 0, 16'hBBBB,  0, 1, 16'hAAAA, 1, 16'h3C3C, 16'hFFFF, 2'b11); // 36
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 1, 16'hBBBB, 1, 16'h3C3C, 16'hFFFF, 2'b11); // 37
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  0, 0, 16'hBBBB, 1, 16'h3C3C, 16'hFFFF, 2'b11); // 38
        addVec(0, 16'h0000, 2'b00, 0, 16'h0000,  1, 0, 16'hBBBB, 0, 16'h3C3C, 16'hFFFF, 2'b11); // 39

        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        $display("[TB] reset released, running %0d table steps", vecs.size());

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].be, vecs[i].ri, vecs[i].dqi);
            @(negedge clk);
            checkOutput("wr_ready", i, {15'd0, bus.wr_ready}, {15'd0, vecs[i].e_wr});
            checkOutput("rd_valid", i, {15'd0, bus.rd_valid}, {15'd0, vecs[i].e_rv});
            checkOutput("rd_data",  i, bus.rd_data, vecs[i].e_rd);
            checkOutput("busy",     i, {15'd0, bus.busy}, {15'd0, vecs[i].e_busy});
            checkOutput("dq_o",     i, dq_o, vecs[i].e_dqo);
            checkOutput("dq_t",     i, dq_t, vecs[i].e_dqt);
            checkOutput("dm_o",     i, {14'd0, dm_o}, {14'd0, vecs[i].e_dm});
        end

        // Reset one cycle after a read is issued: that read must vanish without rd_valid.
        @(posedge clk);
        #1 applyStimulus(1'b0, 16'h0000, 2'b00, 1'b1, 16'h0000);
        @(posedge clk);
        #1 applyStimulus(1'b0, 16'h0000, 2'b00, 1'b0, 16'hDEAD);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy",     100, {15'd0, bus.busy}, 16'd0);
        checkOutput("rst_dq_t",     100, dq_t, 16'hFFFF);
        checkOutput("rst_dm_o",     100, {14'd0, dm_o}, 16'd3);
        checkOutput("rst_rd_data",  100, bus.rd_data, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("rst_wr_ready", 101, {15'd0, bus.wr_ready}, 16'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("rst_rd_valid", 102 + k, {15'd0, bus.rd_valid}, 16'd0);
            checkOutput("rst_busy2",    102 + k, {15'd0, bus.busy}, 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpdmc_dqbus.md
Name: hpdmc_dqbus

Overview:
Parametrised, registered SDRAM DQ/DM datapath front-end for the HPDMC controller. It replaces the fixed 16-bit tristate wrapper with a generic-width block. The block registers write data, DM and per-bit tristate enables, captures read data after a programmable CAS latency, and enforces a read-to-write bus turnaround so that the FPGA never drives DQ while the SDRAM may still be driving it. The pad-side outputs (dq_o, dq_t, dq_i) connect one-to-one to an external IOBUF array.

Parameters:
DW, 16, DQ width in bits; must be a multiple of 8 and at least 8.
CL, 2, cycles from rd_issue to the sampling edge of dq_i; range 1..7.
TURN, 1, idle cycles between the last read capture and the first write drive; range 0..7.

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge.
sys_rst_n  in  1  asynchronous reset, active-low.
wr_valid  in  1  write beat request.
wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
wr_data  in  DW  write beat data.
wr_be  in  DW/8  byte enables; 1 = write this byte.
rd_issue  in  1  one-cycle pulse: a read beat was commanded to the SDRAM this cycle.
rd_data  out  DW  captured read beat.
rd_valid  out  1  one-cycle qualifier for rd_data.
busy  out  1  reads in flight, turnaround pending, or bus driven.
dq_i  in  DW  pad input from the IOBUF O pins.
dq_o  out  DW  pad output data to the IOBUF I pins.
dq_t  out  DW  per-bit tristate to the IOBUF T pins; 1 = hi-Z.
dm_o  out  DW/8  SDRAM data mask; 1 = byte masked.

Behaviour:
- Reset (async, sys_rst_n low):
  - dq_t all 1; dq_o 0; dm_o all 1.
  - rd_data 0; rd_valid 0.
  - Read pipeline cleared; turnaround counter 0; state IDLE.
  - Reads in flight at reset are discarded and never produce rd_valid.
- FSM states:
  - IDLE: bus released, writes allowed.
  - DRIVE: bus driven for one cycle per accepted beat.
  - READ: at least one read in flight.
  - TURN: counter is nonzero.
- wr_ready = (state IDLE or DRIVE) && pipeline empty && counter==0 && !rd_issue. It is combinational. rd_issue has priority over a write in the same cycle.
- Write accept in cycle t: in cycle t+1, dq_o=wr_data, dm_o=~wr_be, dq_t all 0, state DRIVE.
  - With back-to-back accepts the bus stays driven continuously.
  - With no accept in cycle t, in cycle t+1 dq_t returns to all 1 and dm_o to all 1. dq_o holds its last value.
- Read pipeline: a CL-stage shift register of rd_issue tags.
  - The tag from rd_issue in cycle t reaches the last stage in cycle t+CL, and dq_i is sampled at the end of cycle t+CL.
  - rd_data/rd_valid appear in cycle t+CL+1. Total latency is CL+1 cycles.
  - Back-to-back rd_issue pulses give back-to-back rd_valid.
  - rd_data holds its value when rd_valid is 0.
- rd_issue while in DRIVE is legal, because capture happens CL>=1 cycles later, after the drive ends.
- Turnaround:
  - When the pipeline transitions to empty, the counter loads TURN (state TURN); with TURN=0 the state goes straight to IDLE.
  - The counter decrements each cycle and the state goes to IDLE when it reaches 0.
  - A new rd_issue during TURN clears the counter and enters READ. The counter reloads when that read drains.
- busy = pipeline nonempty || counter!=0 || any dq_t bit 0.
- Write-to-read spacing is the controller's responsibility and is not checked here.

Test Plan:
- Reset release, DW=16: dq_t=16'hFFFF, dm_o=2'b11, rd_valid=0, wr_ready=1, busy=0.
- Single write: wr_data=16'hA55A, wr_be=2'b01 accepted at t. At t+1: dq_o=16'hA55A, dm_o=2'b10, dq_t=16'h0000. At t+2: dq_t=16'hFFFF, busy=0.
- Read with CL=2: rd_issue at t, dq_i=16'h1234 during t+2 only. Required: rd_valid=1 and rd_data=16'h1234 at t+3; rd_valid=0 at t+2 and t+4.
- Turnaround with CL=2, TURN=2: rd_issue at t with wr_valid held high. Required: wr_ready=0 through t+4, wr_ready=1 at t+5, first dq_t=0 at t+6.
- Simultaneous events: rd_issue and wr_valid both asserted in IDLE. Required: no write accepted that cycle and dq_t stays all 1. A second rd_issue during TURN restarts the turnaround after its own capture.
- Reset mid-operation: assert sys_rst_n=0 one cycle after rd_issue, release two cycles later. Required: no rd_valid ever appears and wr_ready=1 immediately after release.
